// File: rtl/dsp_pkg.sv
// Shared types and helpers for the DSP multiply-accumulate slice:
// pre-adder opcodes, frame FSM states and the overflow-aware adder.
package dsp_pkg;

  typedef enum logic [1:0] {
    PRE_B     = 2'b00,
    PRE_ADD   = 2'b01,
    PRE_SUB   = 2'b10,
    PRE_B_ALT = 2'b11
  } preop_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

  localparam int SAT_W = 128;

  typedef struct packed {
    logic signed [SAT_W-1:0] sum;
    logic                    ovf;
  } sat_res_t;

  function automatic int pre_width(input int bw, input int dw);
    return ((bw > dw) ? bw : dw) + 1;
  endfunction

  // Adds two values that already fit in 'width' signed bits; the result is
  // clipped or wrapped back into 'width' bits and sign-extended to SAT_W.
  function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] a,
                                       input logic signed [SAT_W-1:0] b,
                                       input int width,
                                       input logic saturate);
    logic [SAT_W-1:0]        one;
    logic signed [SAT_W-1:0] exact;
    logic signed [SAT_W-1:0] maxv;
    logic signed [SAT_W-1:0] minv;
    logic signed [SAT_W-1:0] shl;
    sat_res_t                res;
    one     = SAT_W'(1);
    exact   = a + b;
    maxv    = $signed((one << (width - 1)) - one);
    minv    = ~maxv;
    shl     = exact <<< (SAT_W - width);
    res.ovf = (exact > maxv) || (exact < minv);
    if (!res.ovf)
      res.sum = exact;
    else if (saturate)
      res.sum = (exact > maxv) ? maxv : minv;
    else
      res.sum = shl >>> (SAT_W - width);
    return res;
  endfunction

endpackage

// File: rtl/dsp_preadd.sv
// Registered pre-adder: sign-extends B and D to one extra bit and forms
// B, D+B or D-B according to the opcode.
module dsp_preadd import dsp_pkg::*; #(
  parameter int B_WIDTH = 18,
  parameter int D_WIDTH = 18
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    ce_i,
  input  logic [B_WIDTH-1:0]                      b_i,
  input  logic [D_WIDTH-1:0]                      d_i,
  input  logic [1:0]                              preop_i,
  output logic [pre_width(B_WIDTH, D_WIDTH)-1:0]  pre_o
);

  localparam int PW = pre_width(B_WIDTH, D_WIDTH);

  logic signed [PW-1:0] bExt;
  logic signed [PW-1:0] dExt;
  logic signed [PW-1:0] pre_d;
  logic signed [PW-1:0] pre_q;

  assign bExt = PW'($signed(b_i));
  assign dExt = PW'($signed(d_i));

  always_comb begin
    pre_d = bExt;
    case (preop_e'(preop_i))
      PRE_ADD: pre_d = dExt + bExt;
      PRE_SUB: pre_d = dExt - bExt;
      default: pre_d = bExt;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      pre_q <= '0;
    else if (ce_i)
      pre_q <= pre_d;
  end

  assign pre_o = pre_q;

endmodule

// File: rtl/dsp_mac_acc.sv
// Pipelined pre-add / multiply / accumulate engine with a frame sequencer
// that dumps a saturated (or wrapped) sum after a programmable product count.
module dsp_mac_acc import dsp_pkg::*; #(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 18,
  parameter int D_WIDTH   = 18,
  parameter int P_WIDTH   = 48,
  parameter int MREG      = 1,
  parameter int SATURATE  = 1,
  parameter int LEN_WIDTH = 8
) (
  input  logic                                           clk,
  input  logic                                           RST,
  input  logic                                           CE,
  input  logic                                           start,
  input  logic [LEN_WIDTH-1:0]                           acc_len,
  input  logic                                           in_valid,
  input  logic [A_WIDTH-1:0]                             A,
  input  logic [B_WIDTH-1:0]                             B,
  input  logic [D_WIDTH-1:0]                             D,
  input  logic [1:0]                                     preop,
  output logic [A_WIDTH+pre_width(B_WIDTH, D_WIDTH)-1:0] M,
  output logic [P_WIDTH-1:0]                             P,
  output logic                                           P_valid,
  output logic                                           OVF,
  output logic                                           busy
);

  localparam int PW = pre_width(B_WIDTH, D_WIDTH);
  localparam int MW = A_WIDTH + PW;

  logic [A_WIDTH-1:0]   a1_q;
  logic [B_WIDTH-1:0]   b1_q;
  logic [D_WIDTH-1:0]   d1_q;
  logic [1:0]           op1_q;
  logic                 v1_q;
  logic [A_WIDTH-1:0]   a2_q;
  logic                 v2_q;
  logic [PW-1:0]        pre2;
  logic signed [MW-1:0] prod;
  logic [MW-1:0]        mAcc;
  logic                 vAcc;

  always_ff @(posedge clk) begin
    if (RST) begin
      a1_q  <= '0;
      b1_q  <= '0;
      d1_q  <= '0;
      op1_q <= '0;
      v1_q  <= 1'b0;
      a2_q  <= '0;
      v2_q  <= 1'b0;
    end else if (CE) begin
      a1_q  <= A;
      b1_q  <= B;
      d1_q  <= D;
      op1_q <= preop;
      v1_q  <= in_valid;
      a2_q  <= a1_q;
      v2_q  <= v1_q;
    end
  end

  dsp_preadd #(
    .B_WIDTH(B_WIDTH),
    .D_WIDTH(D_WIDTH)
  ) u_preadd (
    .clk_i  (clk),
    .rst_i  (RST),
    .ce_i   (CE),
    .b_i    (b1_q),
    .d_i    (d1_q),
    .preop_i(op1_q),
    .pre_o  (pre2)
  );

  assign prod = MW'($signed(a2_q)) * MW'($signed(pre2));

  if (MREG != 0) begin : gMreg
    logic [MW-1:0] m_q;
    logic          v3_q;
    always_ff @(posedge clk) begin
      if (RST) begin
        m_q  <= '0;
        v3_q <= 1'b0;
      end else if (CE) begin
        m_q  <= prod;
        v3_q <= v2_q;
      end
    end
    assign mAcc = m_q;
    assign vAcc = v3_q;
  end else begin : gMcomb
    assign mAcc = prod;
    assign vAcc = v2_q;
  end

  assign M = mAcc;

  state_e               state_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] cnt_q;
  logic [P_WIDTH-1:0]   acc_q;
  logic [P_WIDTH-1:0]   p_q;
  logic                 pValid_q;
  logic                 ovf_q;
  sat_res_t             addRes;
  logic [P_WIDTH-1:0]   acc_d;
  logic                 ovf_d;
  logic                 lastProd;

  // A sum whose upper bits are not a clean sign extension of P_WIDTH also
  // counts as overflow, so the whole wide adder result feeds the flag.
  always_comb begin
    addRes   = sat_add(SAT_W'($signed(acc_q)), SAT_W'($signed(mAcc)), P_WIDTH, SATURATE != 0);
    acc_d    = addRes.sum[P_WIDTH-1:0];
    ovf_d    = addRes.ovf
             | (|(addRes.sum[SAT_W-1:P_WIDTH] ^ {(SAT_W-P_WIDTH){addRes.sum[P_WIDTH-1]}}));
    lastProd = (cnt_q == len_q - LEN_WIDTH'(1));
  end

  // Frame sequencer: start always wins and swallows the product at ACC.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      p_q      <= '0;
      pValid_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (CE) begin
      pValid_q <= 1'b0;
      if (start) begin
        state_q <= ST_ACC;
        len_q   <= (acc_len == '0) ? LEN_WIDTH'(1) : acc_len;
        cnt_q   <= '0;
        acc_q   <= '0;
        ovf_q   <= 1'b0;
      end else if (state_q == ST_ACC && vAcc) begin
        ovf_q <= ovf_q | ovf_d;
        if (lastProd) begin
          p_q      <= acc_d;
          pValid_q <= 1'b1;
          acc_q    <= '0;
          cnt_q    <= '0;
          state_q  <= ST_IDLE;
        end else begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + LEN_WIDTH'(1);
        end
      end
    end
  end

  assign P       = p_q;
  assign P_valid = pValid_q;
  assign OVF     = ovf_q;
  assign busy    = (state_q == ST_ACC);

endmodule

// File: tb/tb_dsp_mac_acc.sv
// Directed bench for dsp_mac_acc: four instances (registered/combinational
// multiplier, 48-bit and 40-bit saturating/wrapping results) share one stimulus.
module tb_dsp_mac_acc;

  logic        clk = 1'b0;
  logic        RST, CE, start, in_valid;
  logic [7:0]  acc_len;
  logic [17:0] A, B, D;
  logic [1:0]  preop;

  logic [36:0] mA, mB, mC, mD;
  logic [47:0] pA, pB;
  logic [39:0] pC, pD;
  logic        pvA, pvB, pvC, pvD;
  logic        ovfA, ovfB, ovfC, ovfD;
  logic        busyA, busyB, busyC, busyD;

  always #5 clk = ~clk;

  dsp_mac_acc #(.P_WIDTH(48), .MREG(1), .SATURATE(1)) dutA (
    .clk(clk), .RST(RST), .CE(CE), .start(start), .acc_len(acc_len), .in_valid(in_valid),
    .A(A), .B(B), .D(D), .preop(preop), .M(mA), .P(pA), .P_valid(pvA), .OVF(ovfA), .busy(busyA));
  dsp_mac_acc #(.P_WIDTH(48), .MREG(0), .SATURATE(1)) dutB (
    .clk(clk), .RST(RST), .CE(CE), .start(start), .acc_len(acc_len), .in_valid(in_valid),
    .A(A), .B(B), .D(D), .preop(preop), .M(mB), .P(pB), .P_valid(pvB), .OVF(ovfB), .busy(busyB));
  dsp_mac_acc #(.P_WIDTH(40), .MREG(1), .SATURATE(1)) dutC (
    .clk(clk), .RST(RST), .CE(CE), .start(start), .acc_len(acc_len), .in_valid(in_valid),
    .A(A), .B(B), .D(D), .preop(preop), .M(mC), .P(pC), .P_valid(pvC), .OVF(ovfC), .busy(busyC));
  dsp_mac_acc #(.P_WIDTH(40), .MREG(1), .SATURATE(0)) dutD (
    .clk(clk), .RST(RST), .CE(CE), .start(start), .acc_len(acc_len), .in_valid(in_valid),
    .A(A), .B(B), .D(D), .preop(preop), .M(mD), .P(pD), .P_valid(pvD), .OVF(ovfD), .busy(busyD));

  typedef struct {
    int         len;
    longint     a, b, d;
    logic [1:0] op;
    int         n;
    longint     expAB, expC, expD;
    logic       ovfAB, ovfC, ovfD;
  } vec_t;

  vec_t     vecs[7];
  int       checks = 0;
  int       errors = 0;
  int       cyc = 0;
  int       lastEdge = 0;
  int       pvCnt[4] = '{default: 0};
  int       pvCyc[4] = '{default: 0};
  int       expPv[4] = '{default: 0};
  longint   pVal[4];
  logic [3:0] pvAll, ovfAll, busyAll;
  string    dn[4] = '{"dutA", "dutB", "dutC", "dutD"};
  int       latExp[4] = '{3, 2, 3, 3};

  assign pvAll   = {pvD, pvC, pvB, pvA};
  assign ovfAll  = {ovfD, ovfC, ovfB, ovfA};
  assign busyAll = {busyD, busyC, busyB, busyA};

  always_comb begin
    pVal[0] = longint'($signed(pA));
    pVal[1] = longint'($signed(pB));
    pVal[2] = longint'($signed(pC));
    pVal[3] = longint'($signed(pD));
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Each negedge with P_valid high is one counted pulse cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++)
      if (pvAll[k]) begin
        pvCnt[k] = pvCnt[k] + 1;
        pvCyc[k] = cyc;
      end
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    in_valid = 1'b0;
    start    = 1'b0;
    A = '0; B = '0; D = '0; preop = 2'b00;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    start = 1'b1; acc_len = 8'(v.len); in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < v.n; i++) begin
      A = 18'(v.a); B = 18'(v.b); D = 18'(v.d); preop = v.op; in_valid = 1'b1;
      lastEdge = cyc + 1;
      @(negedge clk);
    end
    idleInputs();
    repeat (6) @(negedge clk);
    #1;
  endtask

  task automatic checkFrame(input string tag, input longint eAB, input longint eC, input longint eD,
                            input logic oAB, input logic oC, input logic oD);
    longint eP[4];
    logic   eO[4];
    eP = '{eAB, eAB, eC, eD};
    eO = '{oAB, oAB, oC, oD};
    for (int k = 0; k < 4; k++) begin
      expPv[k]++;
      checkOutput($sformatf("%s P %s", tag, dn[k]), pVal[k], eP[k]);
      checkOutput($sformatf("%s OVF %s", tag, dn[k]), longint'(ovfAll[k]), longint'(eO[k]));
      checkOutput($sformatf("%s pulses %s", tag, dn[k]), pvCnt[k], expPv[k]);
      checkOutput($sformatf("%s busy %s", tag, dn[k]), longint'(busyAll[k]), 0);
    end
  endtask

  initial begin
    vecs[0] = '{len:4,  a:3,  b:5,  d:0,  op:2'b00, n:4, expAB:60,  expC:60,  expD:60,
                ovfAB:1'b0, ovfC:1'b0, ovfD:1'b0};
    vecs[1] = '{len:1,  a:-2, b:-4, d:10, op:2'b01, n:1, expAB:-12, expC:-12, expD:-12,
                ovfAB:1'b0, ovfC:1'b0, ovfD:1'b0};
    vecs[2] = '{len:1,  a:-2, b:-4, d:10, op:2'b10, n:1, expAB:-28, expC:-28, expD:-28,
                ovfAB:1'b0, ovfC:1'b0, ovfD:1'b0};
    vecs[3] = '{len:1,  a:-2, b:-4, d:10, op:2'b11, n:1, expAB:8,   expC:8,   expD:8,
                ovfAB:1'b0, ovfC:1'b0, ovfD:1'b0};
    vecs[4] = '{len:0,  a:7,  b:3,  d:0,  op:2'b00, n:1, expAB:21,  expC:21,  expD:21,
                ovfAB:1'b0, ovfC:1'b0, ovfD:1'b0};
    vecs[5] = '{len:3,  a:-5, b:7,  d:-9, op:2'b01, n:3, expAB:30,  expC:30,  expD:30,
                ovfAB:1'b0, ovfC:1'b0, ovfD:1'b0};
    vecs[6] = '{len:20, a:-131072, b:-131072, d:131071, op:2'b10, n:20,
                expAB:-64'sd687192145920, expC:-64'sd549755813888, expD:64'sd412319481856,
                ovfAB:1'b0, ovfC:1'b1, ovfD:1'b1};

    // Reset held with busy-looking inputs.
    RST = 1'b1; CE = 1'b1; start = 1'b1; in_valid = 1'b1; acc_len = 8'd4;
    A = 18'd3; B = 18'd5; D = '0; preop = 2'b00;
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("reset P %s", dn[k]), pVal[k], 0);
      checkOutput($sformatf("reset P_valid %s", dn[k]), longint'(pvAll[k]), 0);
      checkOutput($sformatf("reset OVF %s", dn[k]), longint'(ovfAll[k]), 0);
      checkOutput($sformatf("reset busy %s", dn[k]), longint'(busyAll[k]), 0);
    end
    checkOutput("reset M dutA", longint'($signed(mA)), 0);
    checkOutput("reset M dutB", longint'($signed(mB)), 0);

    RST = 1'b0; start = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("no start pulses %s", dn[k]), pvCnt[k], 0);
      checkOutput($sformatf("no start busy %s", dn[k]), longint'(busyAll[k]), 0);
    end
    checkOutput("product M dutA", longint'($signed(mA)), 15);
    checkOutput("product M dutB", longint'($signed(mB)), 15);
    idleInputs();
    repeat (4) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      checkFrame($sformatf("vec%0d", i), vecs[i].expAB, vecs[i].expC, vecs[i].expD,
                 vecs[i].ovfAB, vecs[i].ovfC, vecs[i].ovfD);
      for (int k = 0; k < 4; k++)
        checkOutput($sformatf("vec%0d latency %s", i, dn[k]), pvCyc[k] - lastEdge, latExp[k]);
    end

    // A fresh start must drop the sticky overflow.
    @(negedge clk);
    start = 1'b1; acc_len = 8'd1;
    @(negedge clk);
    start = 1'b0;
    #1;
    checkOutput("start clears OVF dutC", longint'(ovfC), 0);
    checkOutput("start clears OVF dutD", longint'(ovfD), 0);
    checkOutput("start sets busy dutA", longint'(busyA), 1);

    // Abort: restart lands on the cycle dutA's second old product reaches ACC.
    @(negedge clk); start = 1'b1; acc_len = 8'd4;
    @(negedge clk); start = 1'b0; A = 18'd1; B = 18'd1; in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk); idleInputs();
    @(negedge clk);
    @(negedge clk); start = 1'b1; acc_len = 8'd2;
    @(negedge clk); start = 1'b0; A = 18'd2; B = 18'd2; in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk); idleInputs();
    repeat (6) @(negedge clk);
    #1;
    checkFrame("abort", 8, 8, 8, 1'b0, 1'b0, 1'b0);

    // Clock-enable freeze mid-frame with noisy inputs.
    @(negedge clk); start = 1'b1; acc_len = 8'd4;
    @(negedge clk); start = 1'b0; A = 18'd3; B = 18'd5; in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk); idleInputs();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      CE = 1'b0;
      A = 18'($urandom); B = 18'($urandom); D = 18'($urandom);
      in_valid = 1'($urandom); start = 1'($urandom); acc_len = 8'($urandom);
    end
    @(negedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("freeze P %s", dn[k]), pVal[k], 8);
      checkOutput($sformatf("freeze busy %s", dn[k]), longint'(busyAll[k]), 1);
      checkOutput($sformatf("freeze pulses %s", dn[k]), pvCnt[k], expPv[k]);
    end
    checkOutput("freeze M dutA", longint'($signed(mA)), 15);
    checkOutput("freeze M dutB", longint'($signed(mB)), 15);
    CE = 1'b1; start = 1'b0; D = '0; preop = 2'b00; A = 18'd3; B = 18'd5; in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk); idleInputs();
    repeat (6) @(negedge clk);
    #1;
    checkFrame("resume", 60, 60, 60, 1'b0, 1'b0, 1'b0);

    // P_valid must hold while CE is low.
    @(negedge clk); start = 1'b1; acc_len = 8'd1;
    @(negedge clk); start = 1'b0; A = 18'd7; B = 18'd3; in_valid = 1'b1;
    @(negedge clk); idleInputs();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); CE = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("hold P_valid dutA", longint'(pvA), 1);
    checkOutput("hold P_valid dutB", longint'(pvB), 0);
    CE = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    expPv[0] += 2; expPv[2] += 2; expPv[3] += 2;
    checkFrame("hold", 21, 21, 21, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a frame: nothing is dumped.
    @(negedge clk); start = 1'b1; acc_len = 8'd2;
    @(negedge clk); start = 1'b0; A = 18'd1; B = 18'd1; in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk); idleInputs(); RST = 1'b1;
    @(negedge clk); RST = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("midreset P %s", dn[k]), pVal[k], 0);
      checkOutput($sformatf("midreset pulses %s", dn[k]), pvCnt[k], expPv[k]);
      checkOutput($sformatf("midreset busy %s", dn[k]), longint'(busyAll[k]), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
